// File: rtl/deparser_pkg.sv
// Shared encodings for the multi-action sub-deparser: container types, action field layout,
// list sizing and the derived action-index width.
package deparser_pkg;

  localparam int unsigned NUM_ACT         = 10;
  localparam int unsigned C_PARSE_ACT_LEN = 16;
  localparam int unsigned N_8B            = 8;
  localparam int unsigned N_4B            = 8;
  localparam int unsigned N_2B            = 8;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_2B   = 2'b01;
  localparam logic [1:0] T_4B   = 2'b10;
  localparam logic [1:0] T_8B   = 2'b11;

  localparam int unsigned ACT_VLD_BIT  = 15;
  localparam int unsigned ACT_TYPE_LSB = 0;

  // Action layout: [15] valid, [14:13] reserved, [12:5] offset, [4:2] index, [1:0] type.
  typedef struct packed {
    logic       vld;
    logic [1:0] rsvd;
    logic [7:0] off;
    logic [2:0] idx;
    logic [1:0] typ;
  } act_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Index must also represent NUM_ACT itself, the "list walked" value.
  localparam int unsigned IDX_W = clog2(NUM_ACT + 1);

endpackage

// File: rtl/sub_deparser_lane_pack.sv
// Splits one container into even/odd byte sets and steers them onto the two header RAM banks.
module sub_deparser_lane_pack
  import deparser_pkg::*;
(
  input  logic [63:0] cont_i,
  input  logic [1:0]  typ_i,
  input  logic        par_i,
  input  logic [6:0]  word_i,
  output logic [31:0] val1_o,
  output logic [31:0] val2_o,
  output logic [3:0]  be1_o,
  output logic [3:0]  be2_o,
  output logic [6:0]  off1_o,
  output logic [6:0]  off2_o
);

  logic [31:0] ev;
  logic [31:0] od;
  logic [3:0]  be;

  always_comb begin
    unique case (typ_i)
      T_2B:    be = 4'h1;
      T_4B:    be = 4'h3;
      T_8B:    be = 4'hF;
      default: be = 4'h0;
    endcase
    ev = '0;
    od = '0;
    for (int j = 0; j < 4; j++) begin
      if (be[j]) begin
        ev[8*j +: 8] = cont_i[16*j +: 8];
        od[8*j +: 8] = cont_i[16*j + 8 +: 8];
      end
    end
  end

  // Odd start word: odd bytes land one word further up on bank 1, wrapping at 128.
  assign val1_o = par_i ? od : ev;
  assign val2_o = par_i ? ev : od;
  assign off1_o = par_i ? word_i + 7'd1 : word_i;
  assign off2_o = word_i;
  assign be1_o  = be;
  assign be2_o  = be;

endmodule

// File: rtl/sub_deparser_multi.sv
// Multi-action sub-deparser: captures an action list plus container vectors, walks the actions
// through a select stage and a ready/valid output slot, one bank-split beat per valid action.
module sub_deparser_multi
  import deparser_pkg::*;
(
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic                               parse_act_srt,
  input  logic [NUM_ACT*C_PARSE_ACT_LEN-1:0] parse_act,
  input  logic [64*N_8B-1:0]                 i_8B_val,
  input  logic [32*N_4B-1:0]                 i_4B_val,
  input  logic [16*N_2B-1:0]                 i_2B_val,
  output logic                               in_ready,
  output logic                               val_out_valid,
  input  logic                               val_out_ready,
  output logic [31:0]                        val_out1,
  output logic [31:0]                        val_out2,
  output logic [3:0]                         val_out_be1,
  output logic [3:0]                         val_out_be2,
  output logic [6:0]                         val_out_offset1,
  output logic [6:0]                         val_out_offset2,
  output logic [1:0]                         val_out_type,
  output logic                               val_out_end,
  output logic                               list_done,
  output logic                               err_bad_type
);

  localparam int unsigned AL = C_PARSE_ACT_LEN;
  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic                    state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_ACT*AL-1:0]   act_q, act_d;
  logic [64*N_8B-1:0]      c8_q, c8_d;
  logic [32*N_4B-1:0]      c4_q, c4_d;
  logic [16*N_2B-1:0]      c2_q, c2_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;

  logic                    sel_vld_q, sel_vld_d;
  logic [1:0]              sel_typ_q, sel_typ_d;
  logic                    sel_par_q, sel_par_d;
  logic [6:0]              sel_word_q, sel_word_d;
  logic [63:0]             sel_data_q, sel_data_d;
  logic                    sel_end_q, sel_end_d;

  logic                    out_vld_q, out_vld_d;
  logic [31:0]             out1_q, out1_d, out2_q, out2_d;
  logic [3:0]              be1_q, be1_d, be2_q, be2_d;
  logic [6:0]              off1_q, off1_d, off2_q, off2_d;
  logic [1:0]              otype_q, otype_d;
  logic                    oend_q, oend_d;

  act_t                    cur;
  logic [63:0]             cur_data;
  logic [NUM_ACT-1:0]      good;
  logic                    good_cur;
  logic                    later;
  logic                    walking, slot_free, sel_adv, accept, finish;

  logic [31:0]             lp_val1, lp_val2;
  logic [3:0]              lp_be1, lp_be2;
  logic [6:0]              lp_off1, lp_off2;
  logic                    unused_rsvd;

  assign unused_rsvd = ^cur.rsvd;

  // Current action, end-of-list lookahead and container select.
  always_comb begin
    cur   = '0;
    good  = '0;
    later = 1'b0;
    for (int k = 0; k < NUM_ACT; k++) begin
      good[k] = act_q[k*AL + ACT_VLD_BIT] && (act_q[k*AL + ACT_TYPE_LSB +: 2] != T_NONE);
      if (idx_q == IDX_W'(k)) cur = act_t'(act_q[k*AL +: AL]);
    end
    for (int k = 0; k < NUM_ACT; k++) begin
      if ((k > int'(idx_q)) && good[k]) later = 1'b1;
    end
    cur_data = '0;
    unique case (cur.typ)
      T_8B: begin
        for (int i = 0; i < N_8B; i++) if (cur.idx == 3'(i)) cur_data = c8_q[64*i +: 64];
      end
      T_4B: begin
        for (int i = 0; i < N_4B; i++) if (cur.idx == 3'(i)) cur_data = {32'b0, c4_q[32*i +: 32]};
      end
      T_2B: begin
        for (int i = 0; i < N_2B; i++) if (cur.idx == 3'(i)) cur_data = {48'b0, c2_q[16*i +: 16]};
      end
      default: cur_data = '0;
    endcase
  end

  assign good_cur  = cur.vld && (cur.typ != T_NONE);
  assign walking   = (state_q == StRun) && (idx_q < IDX_W'(NUM_ACT));
  assign slot_free = !out_vld_q || val_out_ready;
  assign sel_adv   = !sel_vld_q || slot_free;
  assign accept    = (state_q == StIdle) && parse_act_srt;
  // Done only once the list is walked and both stages are drained (or draining this cycle).
  assign finish    = (state_q == StRun) && !walking && !sel_vld_q && slot_free;

  sub_deparser_lane_pack u_lane_pack (
    .cont_i (sel_data_q),
    .typ_i  (sel_typ_q),
    .par_i  (sel_par_q),
    .word_i (sel_word_q),
    .val1_o (lp_val1),
    .val2_o (lp_val2),
    .be1_o  (lp_be1),
    .be2_o  (lp_be2),
    .off1_o (lp_off1),
    .off2_o (lp_off2)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    act_d      = act_q;
    c8_d       = c8_q;
    c4_d       = c4_q;
    c2_d       = c2_q;
    err_d      = err_q;
    done_d     = 1'b0;
    sel_vld_d  = sel_vld_q;
    sel_typ_d  = sel_typ_q;
    sel_par_d  = sel_par_q;
    sel_word_d = sel_word_q;
    sel_data_d = sel_data_q;
    sel_end_d  = sel_end_q;
    out_vld_d  = out_vld_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    be1_d      = be1_q;
    be2_d      = be2_q;
    off1_d     = off1_q;
    off2_d     = off2_q;
    otype_d    = otype_q;
    oend_d     = oend_q;

    if (accept) begin
      state_d = StRun;
      idx_d   = '0;
      act_d   = parse_act;
      c8_d    = i_8B_val;
      c4_d    = i_4B_val;
      c2_d    = i_2B_val;
      err_d   = 1'b0;
    end

    if (walking && sel_adv) begin
      idx_d = idx_q + 1'b1;
      if (cur.vld && (cur.typ == T_NONE)) err_d = 1'b1;
    end

    if (sel_adv) begin
      sel_vld_d = walking && good_cur;
      if (walking && good_cur) begin
        sel_typ_d  = cur.typ;
        sel_par_d  = cur.off[0];
        sel_word_d = cur.off[7:1];
        sel_data_d = cur_data;
        sel_end_d  = !later;
      end
    end

    if (sel_vld_q && slot_free) begin
      out_vld_d = 1'b1;
      out1_d    = lp_val1;
      out2_d    = lp_val2;
      be1_d     = lp_be1;
      be2_d     = lp_be2;
      off1_d    = lp_off1;
      off2_d    = lp_off2;
      otype_d   = sel_typ_q;
      oend_d    = sel_end_q;
    end else if (val_out_ready) begin
      out_vld_d = 1'b0;
    end

    if (finish) begin
      state_d = StIdle;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      act_q      <= '0;
      c8_q       <= '0;
      c4_q       <= '0;
      c2_q       <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      sel_vld_q  <= 1'b0;
      sel_typ_q  <= '0;
      sel_par_q  <= 1'b0;
      sel_word_q <= '0;
      sel_data_q <= '0;
      sel_end_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out1_q     <= '0;
      out2_q     <= '0;
      be1_q      <= '0;
      be2_q      <= '0;
      off1_q     <= '0;
      off2_q     <= '0;
      otype_q    <= '0;
      oend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      c8_q       <= c8_d;
      c4_q       <= c4_d;
      c2_q       <= c2_d;
      err_q      <= err_d;
      done_q     <= done_d;
      sel_vld_q  <= sel_vld_d;
      sel_typ_q  <= sel_typ_d;
      sel_par_q  <= sel_par_d;
      sel_word_q <= sel_word_d;
      sel_data_q <= sel_data_d;
      sel_end_q  <= sel_end_d;
      out_vld_q  <= out_vld_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      be1_q      <= be1_d;
      be2_q      <= be2_d;
      off1_q     <= off1_d;
      off2_q     <= off2_d;
      otype_q    <= otype_d;
      oend_q     <= oend_d;
    end
  end

  assign in_ready        = (state_q == StIdle);
  assign val_out_valid   = out_vld_q;
  assign val_out1        = out1_q;
  assign val_out2        = out2_q;
  assign val_out_be1     = be1_q;
  assign val_out_be2     = be2_q;
  assign val_out_offset1 = off1_q;
  assign val_out_offset2 = off2_q;
  assign val_out_type    = otype_q;
  assign val_out_end     = oend_q;
  assign list_done       = done_q;
  assign err_bad_type    = err_q;

endmodule
